// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - ALU reservation station with wakeup, age-ordered select and flush
// Optional same-cycle wakeup bypass into select: ISSUE_BYPASS_EN
module alu_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 32,
    parameter int ROB_W     = 5,
    localparam int CW       = $clog2(DEPTH) + 1,
    localparam int IW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dispatch_valid,
    output logic                 dispatch_ready,
    input  logic [6:0]           dispatch_pr1,
    input  logic                 dispatch_pr1_rdy,
    input  logic [6:0]           dispatch_pr2,
    input  logic                 dispatch_pr2_rdy,
    input  logic [6:0]           dispatch_prd,
    input  logic [PAYLOAD_W-1:0] dispatch_payload,
    input  logic [ROB_W-1:0]     dispatch_rob_tag,
    input  logic [2:0]           wakeup_valid,
    input  logic [20:0]          wakeup_tag,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [6:0]           issue_pr1,
    output logic [6:0]           issue_pr2,
    output logic [6:0]           issue_prd,
    output logic [PAYLOAD_W-1:0] issue_payload,
    output logic [ROB_W-1:0]     issue_rob_tag,
    input  logic                 flush,
    output logic [CW-1:0]        count
);

    logic [DEPTH-1:0]     valid_q, rdy1_q, rdy2_q;
    logic [6:0]           pr1_q [DEPTH];
    logic [6:0]           pr2_q [DEPTH];
    logic [6:0]           prd_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [ROB_W-1:0]     rob_q [DEPTH];
    logic [DEPTH-1:0]     age_q [DEPTH];
    logic [CW-1:0]        count_q;

    logic [DEPTH-1:0]     hit1, hit2, eff_rdy1, eff_rdy2, cand;
    logic                 disp_hit1, disp_hit2;
    logic [IW-1:0]        sel_idx, free_idx;
    logic                 free_found, older_all;
    logic                 do_disp, do_issue;

    // A zero tag is the hardwired-ready register and never acts as a broadcast.
    function automatic logic wake_hit(input logic [6:0] pr, input logic [2:0] wv,
                                      input logic [20:0] wt);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (wv[k] && (wt[7*k +: 7] == pr) && (pr != 7'd0)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1[i] = wake_hit(pr1_q[i], wakeup_valid, wakeup_tag);
            hit2[i] = wake_hit(pr2_q[i], wakeup_valid, wakeup_tag);
        end
        disp_hit1 = wake_hit(dispatch_pr1, wakeup_valid, wakeup_tag);
        disp_hit2 = wake_hit(dispatch_pr2, wakeup_valid, wakeup_tag);
    end

`ifdef ISSUE_BYPASS_EN
    assign eff_rdy1 = rdy1_q | hit1;
    assign eff_rdy2 = rdy2_q | hit2;
`else
    assign eff_rdy1 = rdy1_q;
    assign eff_rdy2 = rdy2_q;
`endif

    assign cand = valid_q & eff_rdy1 & eff_rdy2;

    // Exactly one candidate is older than all other candidates when the age matrix is consistent.
    always_comb begin
        sel_idx   = '0;
        older_all = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            older_all = 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && cand[j] && !age_q[i][j]) begin
                    older_all = 1'b0;
                end
            end
            if (cand[i] && older_all) begin
                sel_idx = IW'(i);
            end
        end
    end

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_idx   = IW'(i);
                free_found = 1'b1;
            end
        end
    end

    assign dispatch_ready = (count_q < CW'(DEPTH));
    assign issue_valid    = (|cand) && !flush;
    assign do_disp        = dispatch_valid && dispatch_ready && !flush;
    assign do_issue       = issue_valid && issue_ready;
    assign count          = count_q;

    assign issue_pr1     = issue_valid ? pr1_q[sel_idx]     : '0;
    assign issue_pr2     = issue_valid ? pr2_q[sel_idx]     : '0;
    assign issue_prd     = issue_valid ? prd_q[sel_idx]     : '0;
    assign issue_payload = issue_valid ? payload_q[sel_idx] : '0;
    assign issue_rob_tag = issue_valid ? rob_q[sel_idx]     : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit1[i]) rdy1_q[i] <= 1'b1;
                if (hit2[i]) rdy2_q[i] <= 1'b1;
            end
            if (do_issue) begin
                valid_q[sel_idx] <= 1'b0;
            end
            // Free slot comes from registered valid bits, so it never collides with the issuing slot.
            if (do_disp) begin
                valid_q[free_idx]   <= 1'b1;
                pr1_q[free_idx]     <= dispatch_pr1;
                pr2_q[free_idx]     <= dispatch_pr2;
                prd_q[free_idx]     <= dispatch_prd;
                payload_q[free_idx] <= dispatch_payload;
                rob_q[free_idx]     <= dispatch_rob_tag;
                rdy1_q[free_idx]    <= dispatch_pr1_rdy | (dispatch_pr1 == 7'd0) | disp_hit1;
                rdy2_q[free_idx]    <= dispatch_pr2_rdy | (dispatch_pr2 == 7'd0) | disp_hit2;
                for (int j = 0; j < DEPTH; j++) begin
                    age_q[free_idx][j] <= 1'b0;
                    age_q[j][free_idx] <= valid_q[j];
                end
            end
            case ({do_disp, do_issue})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
